// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, tag-entry layout and FSM encodings for the L1 data cache
package dcache_pkg;

    localparam int TAG_W     = 22;
    localparam int LINE_W    = 256;
    localparam int INDEX_W   = 5;
    localparam int OFFSET_W  = 5;
    localparam int TAG_E_W   = TAG_W + 2;
    localparam int VALID_BIT = 23;
    localparam int DIRTY_BIT = 22;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MISS       = 3'd1,
        READMISS   = 3'd2,
        READMISSOK = 3'd3,
        WRITEBACK  = 3'd4
    } state_t;

endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - single-port array, asynchronous read, synchronous write, no reset
module dcache_sram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dcache_top.sv
// rtl/dcache_top.sv - direct-mapped write-back write-allocate L1 data cache controller
import dcache_pkg::*;

module dcache_top #(
    parameter int LINES = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [31:0]       mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    state_t              r_state;
    logic                r_mem_enable;
    logic                r_mem_write;
    logic [31:0]         r_mem_addr;
    logic [LINE_W-1:0]   r_mem_data;

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [2:0]          w_ws;
    logic [TAG_E_W-1:0]  w_tag_entry;
    logic [TAG_E_W-1:0]  w_tag_wdata;
    logic [LINE_W-1:0]   w_line;
    logic [LINE_W-1:0]   w_merged;
    logic [LINE_W-1:0]   w_line_wdata;
    logic                w_req;
    logic                w_hit;
    logic                w_victim_dirty;
    logic                w_refill;
    logic                w_write_hit;
    logic                w_we;

    assign w_idx = p1_addr_i[OFFSET_W +: INDEX_W];
    assign w_tag = p1_addr_i[31 -: TAG_W];
    assign w_ws  = p1_addr_i[4:2];

    assign w_req          = p1_MemRead_i | p1_MemWrite_i;
    assign w_hit          = w_tag_entry[VALID_BIT] & (w_tag_entry[TAG_W-1:0] == w_tag);
    assign w_victim_dirty = w_tag_entry[VALID_BIT] & w_tag_entry[DIRTY_BIT];

    // Stores seen while the line hits complete in place, including the cycle after a refill.
    assign w_write_hit = rst_i & p1_MemWrite_i & w_hit;
    assign w_refill    = (r_state == READMISS) & mem_ack_i;
    assign w_we        = w_write_hit | w_refill;

    always_comb begin
        w_merged = w_line;
        w_merged[{w_ws, 5'b0} +: 32] = p1_data_i;
    end

    assign w_line_wdata = w_refill ? mem_data_i : w_merged;
    assign w_tag_wdata  = {1'b1, ~w_refill, w_tag};

    dcache_sram #(.DEPTH(LINES), .WIDTH(TAG_E_W)) dcache_tag_sram (
        .clk_i   (clk_i),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (w_tag_wdata),
        .o_rdata (w_tag_entry)
    );

    dcache_sram #(.DEPTH(LINES), .WIDTH(LINE_W)) dcache_data_sram (
        .clk_i   (clk_i),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (w_line_wdata),
        .o_rdata (w_line)
    );

    assign p1_stall_o = w_req & ~w_hit;
    assign p1_data_o  = p1_MemRead_i ? w_line[{w_ws, 5'b0} +: 32] : 32'h0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= IDLE;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req & ~w_hit) begin
                        r_state <= MISS;
                    end
                end
                MISS: begin
                    r_mem_enable <= 1'b1;
                    if (w_victim_dirty) begin
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= {w_tag_entry[TAG_W-1:0], w_idx, 5'b0};
                        r_mem_data  <= w_line;
                        r_state     <= WRITEBACK;
                    end else begin
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= {w_tag, w_idx, 5'b0};
                        r_state     <= READMISS;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= {w_tag, w_idx, 5'b0};
                        r_state     <= READMISS;
                    end
                end
                READMISS: begin
                    if (mem_ack_i) begin
                        r_mem_enable <= 1'b0;
                        r_state      <= READMISSOK;
                    end
                end
                READMISSOK: r_state <= IDLE;
                default:    r_state <= IDLE;
            endcase
        end
    end

    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_mem_write;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;

endmodule

// File: tb/tb_dcache_top.sv
// tb/tb_dcache_top.sv - directed self-checking bench for dcache_top
import dcache_pkg::*;

module tb_dcache_top;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [31:0]       p1_addr_i;
    logic [31:0]       p1_data_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_o;
    logic [31:0]       mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;

    int checks = 0;
    int errors = 0;

    logic [LINE_W-1:0] line_a, line_b, line_c, line_d, exp_l0;

    dcache_top dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", dut.r_state, IDLE); end
        checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL rst_enable got %b exp 0", mem_enable_o); end
        checks++; if (mem_write_o !== 1'b0) begin errors++; $display("FAIL rst_write got %b exp 0", mem_write_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", mem_addr_o); end
        checks++; if (mem_data_o !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", mem_data_o); end
        checks++; if (p1_stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", p1_stall_o); end
        checks++; if (p1_data_o !== 32'h0) begin errors++; $display("FAIL rst_p1data got %h exp 0", p1_data_o); end
    endtask

    task automatic test_cold_load();
        p1_addr_i = 32'h0; p1_MemRead_i = 1'b1; #1;
        checks++; if (p1_stall_o !== 1'b1) begin errors++; $display("FAIL cold_stall0 got %b exp 1", p1_stall_o); end
        tick();
        checks++; if (dut.r_state !== MISS) begin errors++; $display("FAIL cold_miss got %0d exp %0d", dut.r_state, MISS); end
        tick();
        checks++; if (dut.r_state !== READMISS) begin errors++; $display("FAIL cold_rm got %0d exp %0d", dut.r_state, READMISS); end
        checks++; if ({mem_enable_o, mem_write_o} !== 2'b10) begin errors++; $display("FAIL cold_en_wr got %b exp 10", {mem_enable_o, mem_write_o}); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL cold_addr got %h exp 0", mem_addr_o); end
        checks++; if (p1_stall_o !== 1'b1) begin errors++; $display("FAIL cold_stall2 got %b exp 1", p1_stall_o); end
        mem_data_i = line_a; mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        checks++; if (dut.r_state !== READMISSOK) begin errors++; $display("FAIL cold_rmok got %0d exp %0d", dut.r_state, READMISSOK); end
        checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL cold_en_drop got %b exp 0", mem_enable_o); end
        checks++; if (p1_stall_o !== 1'b0) begin errors++; $display("FAIL cold_stall_end got %b exp 0", p1_stall_o); end
        checks++; if (p1_data_o !== 32'h5) begin errors++; $display("FAIL cold_data got %h exp 00000005", p1_data_o); end
        tick();
        checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL cold_idle got %0d exp %0d", dut.r_state, IDLE); end
    endtask

    task automatic test_word_select();
        p1_addr_i = 32'h1C; p1_MemRead_i = 1'b1; #1;
        checks++; if (p1_stall_o !== 1'b0) begin errors++; $display("FAIL ws_stall got %b exp 0", p1_stall_o); end
        checks++; if (p1_data_o !== 32'hA0000007) begin errors++; $display("FAIL ws_data got %h exp a0000007", p1_data_o); end
        p1_MemRead_i = 1'b0; mem_ack_i = 1'b1; #1;
        checks++; if (p1_data_o !== 32'h0) begin errors++; $display("FAIL ws_noread got %h exp 0", p1_data_o); end
        tick();
        mem_ack_i = 1'b0;
        checks++; if (dut.r_state !== IDLE || mem_enable_o !== 1'b0) begin errors++; $display("FAIL idle_ack got state %0d en %b exp 0 0", dut.r_state, mem_enable_o); end
    endtask

    task automatic test_store_hit();
        p1_addr_i = 32'h4; p1_data_i = 32'hDEADBEEF; p1_MemWrite_i = 1'b1; #1;
        checks++; if (p1_stall_o !== 1'b0) begin errors++; $display("FAIL sh_stall got %b exp 0", p1_stall_o); end
        tick();
        p1_MemWrite_i = 1'b0;
        checks++; if (dut.dcache_tag_sram.r_mem[0] !== 24'hC00000) begin errors++; $display("FAIL sh_tag got %h exp c00000", dut.dcache_tag_sram.r_mem[0]); end
        checks++; if (dut.dcache_data_sram.r_mem[0] !== line_b) begin errors++; $display("FAIL sh_line got %h exp %h", dut.dcache_data_sram.r_mem[0], line_b); end
    endtask

    task automatic test_conflict_store();
        p1_addr_i = 32'h400; p1_data_i = 32'h12345678; p1_MemWrite_i = 1'b1; #1;
        checks++; if (p1_stall_o !== 1'b1) begin errors++; $display("FAIL cs_stall got %b exp 1", p1_stall_o); end
        tick(); tick();
        checks++; if (dut.r_state !== WRITEBACK) begin errors++; $display("FAIL cs_wb got %0d exp %0d", dut.r_state, WRITEBACK); end
        checks++; if ({mem_enable_o, mem_write_o} !== 2'b11) begin errors++; $display("FAIL cs_wb_en_wr got %b exp 11", {mem_enable_o, mem_write_o}); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL cs_wb_addr got %h exp 0", mem_addr_o); end
        checks++; if (mem_data_o !== line_b) begin errors++; $display("FAIL cs_wb_data got %h exp %h", mem_data_o, line_b); end
        tick();
        checks++; if (dut.r_state !== WRITEBACK) begin errors++; $display("FAIL cs_wb_hold got %0d exp %0d", dut.r_state, WRITEBACK); end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        checks++; if (dut.r_state !== READMISS) begin errors++; $display("FAIL cs_rm got %0d exp %0d", dut.r_state, READMISS); end
        checks++; if ({mem_enable_o, mem_write_o} !== 2'b10) begin errors++; $display("FAIL cs_rm_en_wr got %b exp 10", {mem_enable_o, mem_write_o}); end
        checks++; if (mem_addr_o !== 32'h400) begin errors++; $display("FAIL cs_rm_addr got %h exp 00000400", mem_addr_o); end
        tick();
        mem_data_i = line_c; mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        checks++; if (p1_stall_o !== 1'b0) begin errors++; $display("FAIL cs_stall_end got %b exp 0", p1_stall_o); end
        tick();
        p1_MemWrite_i = 1'b0;
        checks++; if (dut.dcache_tag_sram.r_mem[0] !== 24'hC00001) begin errors++; $display("FAIL cs_tag got %h exp c00001", dut.dcache_tag_sram.r_mem[0]); end
        checks++; if (dut.dcache_data_sram.r_mem[0] !== exp_l0) begin errors++; $display("FAIL cs_line got %h exp %h", dut.dcache_data_sram.r_mem[0], exp_l0); end
    endtask

    task automatic test_delayed_ack();
        p1_addr_i = 32'h28; p1_MemRead_i = 1'b1;
        tick(); tick();
        checks++; if (dut.r_state !== READMISS || mem_addr_o !== 32'h20) begin errors++; $display("FAIL da_rm got state %0d addr %h exp 2 00000020", dut.r_state, mem_addr_o); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (p1_stall_o !== 1'b1 || dut.dcache_tag_sram.r_mem[1] !== 24'h0) begin errors++; $display("FAIL da_wait%0d got stall %b tag %h exp 1 000000", i, p1_stall_o, dut.dcache_tag_sram.r_mem[1]); end
        end
        mem_data_i = line_d; mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        checks++; if (p1_stall_o !== 1'b0 || p1_data_o !== 32'hD0000002) begin errors++; $display("FAIL da_data got stall %b data %h exp 0 d0000002", p1_stall_o, p1_data_o); end
        tick();
        p1_MemRead_i = 1'b0;
    endtask

    task automatic test_reset_mid_writeback();
        p1_addr_i = 32'h0; p1_data_i = 32'h55AA55AA; p1_MemWrite_i = 1'b1;
        tick(); tick();
        checks++; if (dut.r_state !== WRITEBACK || mem_enable_o !== 1'b1) begin errors++; $display("FAIL rw_pre got state %0d en %b exp 4 1", dut.r_state, mem_enable_o); end
        rst_i = 1'b0; #1;
        checks++; if (mem_enable_o !== 1'b0 || dut.r_state !== IDLE) begin errors++; $display("FAIL rw_async got en %b state %0d exp 0 0", mem_enable_o, dut.r_state); end
        tick();
        checks++; if (dut.dcache_tag_sram.r_mem[0] !== 24'hC00001 || dut.dcache_data_sram.r_mem[0] !== exp_l0) begin errors++; $display("FAIL rw_sram got tag %h line %h exp c00001 %h", dut.dcache_tag_sram.r_mem[0], dut.dcache_data_sram.r_mem[0], exp_l0); end
        rst_i = 1'b1; #1;
        checks++; if (p1_stall_o !== 1'b1) begin errors++; $display("FAIL rw_stall got %b exp 1", p1_stall_o); end
        tick(); tick();
        checks++; if (dut.r_state !== WRITEBACK || mem_addr_o !== 32'h400 || mem_data_o !== exp_l0) begin errors++; $display("FAIL rw_wb got state %0d addr %h data %h exp 4 00000400 %h", dut.r_state, mem_addr_o, mem_data_o, exp_l0); end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        checks++; if (mem_addr_o !== 32'h0 || mem_write_o !== 1'b0) begin errors++; $display("FAIL rw_rm got addr %h wr %b exp 0 0", mem_addr_o, mem_write_o); end
        mem_data_i = line_a; mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        tick();
        p1_MemWrite_i = 1'b0;
        checks++; if (dut.dcache_tag_sram.r_mem[0] !== 24'hC00000) begin errors++; $display("FAIL rw_tag got %h exp c00000", dut.dcache_tag_sram.r_mem[0]); end
        checks++; if (dut.dcache_data_sram.r_mem[0][63:0] !== 64'hA0000001_55AA55AA) begin errors++; $display("FAIL rw_line got %h exp a000000155aa55aa", dut.dcache_data_sram.r_mem[0][63:0]); end
    endtask

    initial begin
        rst_i = 1'b0; p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
        mem_data_i = '0; mem_ack_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            line_a[32*k +: 32] = 32'hA0000000 | k;
            line_c[32*k +: 32] = 32'hC0000000 | k;
            line_d[32*k +: 32] = 32'hD0000000 | k;
        end
        line_a[31:0] = 32'h5;
        line_b = line_a; line_b[63:32] = 32'hDEADBEEF;
        exp_l0 = line_c; exp_l0[31:0] = 32'h12345678;
        for (int i = 0; i < 32; i++) begin
            dut.dcache_tag_sram.r_mem[i] = '0;
            dut.dcache_data_sram.r_mem[i] = '0;
        end
        tick(); tick();
        test_reset();
        rst_i = 1'b1;
        tick();
        test_cold_load();
        test_word_select();
        test_store_hit();
        test_conflict_store();
        test_delayed_ack();
        test_reset_mid_writeback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_top.md
Name: dcache_top

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller.
- Sits between the CPU MEM stage (p1_* side) and the off-chip Data_Memory (mem_* side).
- Serves 32-bit word loads and stores from 32 lines of 256 bits each.
- Stalls the pipeline on a miss while it writes back the victim line and/or refills the requested line over the Data_Memory enable/ack handshake.

Parameters:
- LINES, 32, number of cache lines (index width = log2(LINES) = 5).
- LINE_W, 256, line width in bits (32-byte line, 5-bit byte offset).
- TAG_W, 22, address tag bits (addr[31:10]).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- p1_addr_i  in  32  byte address from MEM stage.
- p1_data_i  in  32  store data.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request.
- p1_data_o  out  32  load data.
- p1_stall_o  out  1  stall pipeline.
- mem_data_i  in  256  line from Data_Memory.
- mem_ack_i  in  1  Data_Memory transfer done.
- mem_data_o  out  256  victim line to Data_Memory.
- mem_addr_o  out  32  line address to Data_Memory, bits [4:0] always 0.
- mem_enable_o  out  1  request to Data_Memory.
- mem_write_o  out  1  1 = write back, 0 = refill.

Behaviour:
- Address split: offset = addr[4:0], word select = addr[4:2], index = addr[9:5], tag = addr[31:10].
- Tag SRAM entry is 24 bits: {valid[23], dirty[22], tag[21:0]}.
- SRAM contents are not cleared by reset; the bench zeroes them, so all lines start invalid.
- Request definitions:
  - req = p1_MemRead_i | p1_MemWrite_i.
  - hit = valid & (stored tag == addr tag).
  - If both request inputs are high, the access is a store.
- p1_stall_o = req & ~hit, combinational. It is 0 when there is no request.
- p1_data_o = 32-bit word [32*ws+31 : 32*ws] of the indexed line, combinational. It is 0 when p1_MemRead_i = 0.
- Write hit: at the clock edge, the selected word is merged into the line, and dirty and valid are set. No stall.
- FSM states, in the shared package: IDLE=0, MISS=1, READMISS=2, READMISSOK=3, WRITEBACK=4.
- IDLE: req & ~hit -> MISS.
- MISS:
  - If the victim is dirty: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o = victim line; go to WRITEBACK.
  - Otherwise: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}; go to READMISS.
- WRITEBACK: hold outputs until mem_ack_i.
  - On ack: mem_write_o=0, mem_addr_o = request line address, enable stays 1; go to READMISS.
- READMISS: wait for mem_ack_i.
  - On ack: write mem_data_i to the data SRAM and {1,0,req tag} to the tag SRAM; deassert mem_enable_o; go to READMISSOK.
- READMISSOK: go to IDLE.
  - The next cycle hits, so stall drops.
  - A pending store then completes as a write hit and sets dirty.
- Memory-side outputs are registered. Reset values: mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, FSM=IDLE.
- Ack latency is unbounded; the FSM holds its state indefinitely while waiting.
- A mem_ack_i seen in IDLE or MISS is ignored.
- The upstream pipeline holds p1_* stable while stalled. If the request is withdrawn mid-miss, the FSM still completes the refill and returns to IDLE.
- Reset asserted mid-miss:
  - FSM goes to IDLE and mem_enable_o drops immediately (asynchronous).
  - The partial transfer is abandoned.
  - SRAM contents are unchanged (no partial line write).
- Miss latency from the stall-first cycle to the stall-free cycle:
  - Clean victim: 3 + refill ack latency.
  - Dirty victim: additionally the writeback ack latency.

Decomposition:
- Package dcache_pkg holds:
  - state encodings;
  - TAG_W, LINE_W, INDEX_W=5, OFFSET_W=5;
  - tag-entry bit positions VALID_BIT=23 and DIRTY_BIT=22.
- Sub-modules:
  - dcache_sram: single-port, asynchronous read, synchronous write, depth LINES, width parameterized. Instantiated twice: dcache_tag_sram (24 bits wide) and dcache_data_sram (256 bits wide).
  - The FSM and hit logic stay in dcache_top.

Test Plan:
- Cold load, all lines invalid, Data_Memory[0]=0x5, load 0x00000000:
  - Stall rises and the FSM passes MISS -> READMISS with mem_addr_o=0x0, mem_write_o=0.
  - After ack, the line is written; after READMISSOK stall=0 and p1_data_o=0x00000005.
- Word select: after the line at 0x00000000 is loaded, load 0x0000001C -> p1_data_o = line[255:224] with no stall.
- Store hit at 0x00000004 with data 0xDEADBEEF -> no stall; the next cycle the tag entry has dirty=1 and line[63:32]=0xDEADBEEF.
- Conflict store at 0x00000400 (index 0, tag 1) with a dirty line 0:
  - WRITEBACK first: mem_write_o=1, mem_addr_o=0x0, mem_data_o = old line.
  - Then refill from 0x400.
  - Final tag entry = {1,1,22'h1}, with the word stored at offset 0.
- Ack delayed 10 cycles in READMISS -> stall is held for all 10 cycles; no SRAM write before ack.
- rst_i pulsed low during WRITEBACK:
  - mem_enable_o=0 and FSM=IDLE immediately.
  - Tag and data SRAM unchanged.
  - The re-issued store redoes the full miss sequence.
